// File: rtl/cpu_pkg.sv
// Shared widths, opcodes, condition codes and FSM encoding for the 8-bit CPU.
package cpu_pkg;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int IW = 16;

   localparam logic [3:0] OP_LOAD = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_JCC  = 4'b1001;
   localparam logic [3:0] OP_IN   = 4'b1010;
   localparam logic [3:0] OP_OUT  = 4'b1110;

   localparam logic [1:0] CC_Z  = 2'b00;
   localparam logic [1:0] CC_NZ = 2'b01;
   localparam logic [1:0] CC_C  = 2'b10;
   localparam logic [1:0] CC_NC = 2'b11;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: computes the ACC result and flag updates for LOAD/ADD/SUB/AND.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [DW-1:0] acc_i,
   input  logic [DW-1:0] kk_i,
   input  logic [3:0]    op_i,
   input  logic          c_i,
   output logic [DW-1:0] result_o,
   output logic          c_o,
   output logic          z_o,
   output logic          acc_we_o,
   output logic          z_we_o,
   output logic          c_we_o
);
   logic [DW:0] sum, diff;

   assign sum  = {1'b0, acc_i} + {1'b0, kk_i};
   // bit 8 of the difference is the borrow
   assign diff = {1'b0, acc_i} - {1'b0, kk_i};

   always_comb begin
      result_o = acc_i;
      c_o      = c_i;
      acc_we_o = 1'b0;
      z_we_o   = 1'b0;
      c_we_o   = 1'b0;
      case (op_i)
         OP_LOAD: begin
            result_o = kk_i;
            acc_we_o = 1'b1;
         end
         OP_ADD: begin
            result_o = sum[DW-1:0];
            c_o      = sum[DW];
            acc_we_o = 1'b1;
            z_we_o   = 1'b1;
            c_we_o   = 1'b1;
         end
         OP_SUB: begin
            result_o = diff[DW-1:0];
            c_o      = diff[DW];
            acc_we_o = 1'b1;
            z_we_o   = 1'b1;
            c_we_o   = 1'b1;
         end
         OP_AND: begin
            result_o = acc_i & kk_i;
            acc_we_o = 1'b1;
            z_we_o   = 1'b1;
         end
         default: ;
      endcase
   end

   assign z_o = (result_o == '0);
endmodule

// File: rtl/cpu_controller.sv
// Fetch/wait/exec controller: owns PC, IR, ACC, Z/C flags and the I/O port registers.
module cpu_controller
   import cpu_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   output logic [AW-1:0] ram_addr,
   input  logic [IW-1:0] ram_dout,
   output logic [DW-1:0] in_port,
   input  logic [DW-1:0] in_data,
   output logic [DW-1:0] out_port,
   output logic [DW-1:0] out_data,
   output logic          out_strobe,
   output logic [DW-1:0] acc,
   output logic [AW-1:0] pc
);
   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d, addr_q, addr_d;
   logic [IW-1:0] ir_q, ir_d;
   logic [DW-1:0] acc_q, acc_d, oport_q, oport_d, odata_q, odata_d;
   logic          z_q, z_d, c_q, c_d, ostb_q, ostb_d;

   logic [3:0]    opcode;
   logic [DW-1:0] kk, alu_res;
   logic          alu_c, alu_z, alu_acc_we, alu_z_we, alu_c_we, cc_true;
   logic          unused_ir;

   assign opcode    = ir_q[15:12];
   assign kk        = ir_q[7:0];
   assign unused_ir = ^ir_q[9:8];

   cpu_alu u_alu (
      .acc_i    (acc_q),
      .kk_i     (kk),
      .op_i     (opcode),
      .c_i      (c_q),
      .result_o (alu_res),
      .c_o      (alu_c),
      .z_o      (alu_z),
      .acc_we_o (alu_acc_we),
      .z_we_o   (alu_z_we),
      .c_we_o   (alu_c_we)
   );

   always_comb begin
      case (ir_q[11:10])
         CC_Z:    cc_true = z_q;
         CC_NZ:   cc_true = !z_q;
         CC_C:    cc_true = c_q;
         default: cc_true = !c_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      z_d     = z_q;
      c_d     = c_q;
      addr_d  = addr_q;
      oport_d = oport_q;
      odata_d = odata_q;
      ostb_d  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            addr_d  = pc_q;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            ir_d    = ram_dout;
            pc_d    = pc_q + 8'd1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            if (alu_acc_we) acc_d = alu_res;
            if (alu_z_we)   z_d   = alu_z;
            if (alu_c_we)   c_d   = alu_c;
            case (opcode)
               OP_IN:  acc_d = in_data;
               OP_OUT: begin
                  oport_d = kk;
                  odata_d = acc_q;
                  ostb_d  = 1'b1;
               end
               OP_JMP: pc_d = kk;
               OP_JCC: if (cc_true) pc_d = kk;
               default: ;
            endcase
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         addr_q  <= '0;
         oport_q <= '0;
         odata_q <= '0;
         ostb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         c_q     <= c_d;
         addr_q  <= addr_d;
         oport_q <= oport_d;
         odata_q <= odata_d;
         ostb_q  <= ostb_d;
      end
   end

   // address is live in FETCH so a jump target reaches the RAM without an extra cycle
   assign ram_addr   = (state_q == ST_FETCH) ? pc_q : addr_q;
   assign in_port    = (state_q == ST_EXEC && opcode == OP_IN) ? kk : '0;
   assign out_port   = oport_q;
   assign out_data   = odata_q;
   assign out_strobe = ostb_q;
   assign acc        = acc_q;
   assign pc         = pc_q;
endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller with a synchronous-read program RAM model.
module tb_cpu_controller;
   logic        clock, reset;
   logic [7:0]  ram_addr, in_port, in_data, out_port, out_data, acc, pc;
   logic [15:0] ram_dout;
   logic        out_strobe;
   logic [15:0] mem [256];
   int          n_vec, n_err;

   cpu_controller dut (
      .clock      (clock),
      .reset      (reset),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .in_port    (in_port),
      .in_data    (in_data),
      .out_port   (out_port),
      .out_data   (out_data),
      .out_strobe (out_strobe),
      .acc        (acc),
      .pc         (pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) ram_dout <= mem[ram_addr];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h2000;
   endtask

   // hold reset for two cycles, then release on a negedge: that cycle is the first FETCH
   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b1; in_data = 8'h00;
      clear_mem();
      cyc(2);
      check("rst_pc", pc, 8'h00);
      check("rst_acc", acc, 8'h00);
      check("rst_addr", ram_addr, 8'h00);
      check("rst_oport", out_port, 8'h00);
      check("rst_odata", out_data, 8'h00);
      check("rst_ostb", out_strobe, 1'b0);
      check("rst_z", dut.z_q, 1'b0);
      check("rst_c", dut.c_q, 1'b0);

      // IN 6; ADD 0A; JNZ 4; LOAD FF; OUT 7; JMP 0
      mem[0] = 16'hA006; mem[1] = 16'h400A; mem[2] = 16'h9404;
      mem[3] = 16'h00FF; mem[4] = 16'hE007; mem[5] = 16'h8000;
      in_data = 8'h06;
      do_reset();
      check("p1_f0", ram_addr, 8'h00);
      cyc(2);
      check("p1_inport", in_port, 8'h06);
      cyc(1);
      check("p1_f1", ram_addr, 8'h01);
      check("p1_acc_in", acc, 8'h06);
      check("p1_inport_idle", in_port, 8'h00);
      cyc(3);
      check("p1_f2", ram_addr, 8'h02);
      check("p1_acc_add", acc, 8'h10);
      check("p1_c", dut.c_q, 1'b0);
      cyc(3);
      check("p1_f4", ram_addr, 8'h04);
      check("p1_ostb_pre", out_strobe, 1'b0);
      cyc(3);
      check("p1_f5", ram_addr, 8'h05);
      check("p1_ostb", out_strobe, 1'b1);
      check("p1_oport", out_port, 8'h07);
      check("p1_odata", out_data, 8'h10);
      cyc(1);
      check("p1_ostb_fall", out_strobe, 1'b0);
      cyc(2);
      check("p1_f0b", ram_addr, 8'h00);

      // same program, carry-out makes ACC zero and JNZ falls through
      in_data = 8'hF6;
      do_reset();
      cyc(6);
      check("p2_acc", acc, 8'h00);
      check("p2_z", dut.z_q, 1'b1);
      check("p2_c", dut.c_q, 1'b1);
      cyc(3);
      check("p2_f3", ram_addr, 8'h03);
      cyc(3);
      check("p2_f4", ram_addr, 8'h04);
      check("p2_acc_ld", acc, 8'hFF);
      cyc(3);
      check("p2_ostb", out_strobe, 1'b1);
      check("p2_odata", out_data, 8'hFF);
      check("p2_oport", out_port, 8'h07);

      // LOAD 05; SUB 06; JC 10
      clear_mem();
      mem[0] = 16'h0005; mem[1] = 16'h6006; mem[2] = 16'h9810;
      do_reset();
      cyc(6);
      check("p3_acc", acc, 8'hFF);
      check("p3_c", dut.c_q, 1'b1);
      check("p3_z", dut.z_q, 1'b0);
      cyc(3);
      check("p3_jc", ram_addr, 8'h10);
      check("p3_pc", pc, 8'h10);

      // LOAD 05; SUB 05; JNC 20
      mem[1] = 16'h6005; mem[2] = 16'h9C20;
      do_reset();
      cyc(6);
      check("p4_acc", acc, 8'h00);
      check("p4_z", dut.z_q, 1'b1);
      check("p4_c", dut.c_q, 1'b0);
      cyc(3);
      check("p4_jnc", ram_addr, 8'h20);

      // LOAD FF; ADD 02 (sets C); LOAD F0; AND 0F; opcode-2 NOP
      clear_mem();
      mem[0] = 16'h00FF; mem[1] = 16'h4002; mem[2] = 16'h00F0;
      mem[3] = 16'h100F; mem[4] = 16'h2123;
      do_reset();
      cyc(6);
      check("p5_acc_add", acc, 8'h01);
      check("p5_c_add", dut.c_q, 1'b1);
      check("p5_z_add", dut.z_q, 1'b0);
      cyc(6);
      check("p5_acc_and", acc, 8'h00);
      check("p5_z_and", dut.z_q, 1'b1);
      check("p5_c_and", dut.c_q, 1'b1);
      check("p5_pc_pre", pc, 8'h04);
      cyc(3);
      check("p5_acc_nop", acc, 8'h00);
      check("p5_z_nop", dut.z_q, 1'b1);
      check("p5_c_nop", dut.c_q, 1'b1);
      check("p5_pc_nop", pc, 8'h05);

      // JMP FF with LOAD 5A at FF: wraps to 00
      clear_mem();
      mem[0] = 16'h80FF; mem[255] = 16'h005A;
      do_reset();
      cyc(3);
      check("p6_fff", ram_addr, 8'hFF);
      cyc(3);
      check("p6_acc", acc, 8'h5A);
      check("p6_wrap_addr", ram_addr, 8'h00);
      check("p6_wrap_pc", pc, 8'h00);

      // reset during EXEC of OUT aborts the strobe
      clear_mem();
      mem[0] = 16'h0033; mem[1] = 16'hE009;
      do_reset();
      cyc(5);
      reset = 1'b1;
      cyc(1);
      check("p7_ostb", out_strobe, 1'b0);
      check("p7_acc", acc, 8'h00);
      check("p7_pc", pc, 8'h00);
      check("p7_addr", ram_addr, 8'h00);
      check("p7_oport", out_port, 8'h00);
      check("p7_odata", out_data, 8'h00);
      reset = 1'b0;
      check("p7_f0", ram_addr, 8'h00);
      cyc(1);
      check("p7_ostb_after", out_strobe, 1'b0);
      cyc(2);
      check("p7_f1", ram_addr, 8'h01);
      check("p7_acc_reload", acc, 8'h33);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
